axi2mem_r_beat_gen: RTL and testbench
=====================================

Name: axi2mem_r_beat_gen

Overview:
Read-path stage of axi2mem, directly upstream of the R-channel buffer. Accepts one AXI AR request at a time and walks the burst (FIXED/INCR/WRAP). For each beat it issues one req/gnt memory read and captures r_valid data. It then presents the beat as an R-channel beat (valid/data/resp/user/id/last) to the downstream R buffer, holding it until accepted.

Parameters:
ADDR_WIDTH, 32, byte address width of AR and memory port
DATA_WIDTH, 64, data width of memory and R channel (power of two, >=8)
ID_WIDTH, 4, AXI ID width
USER_WIDTH, 6, AXI user width
STRB_WIDTH, DATA_WIDTH/8, byte lanes (derived, do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ar_valid_i  in  1  AR request valid
ar_addr_i  in  ADDR_WIDTH  start byte address
ar_len_i  in  8  beats minus one
ar_size_i  in  3  log2 bytes per beat
ar_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
ar_id_i  in  ID_WIDTH  transaction ID
ar_user_i  in  USER_WIDTH  user sideband
ar_ready_o  out  1  AR accepted
mem_req_o  out  1  memory read request
mem_add_o  out  ADDR_WIDTH  beat byte address
mem_we_o  out  1  tied 0
mem_be_o  out  STRB_WIDTH  byte enables for the beat
mem_gnt_i  in  1  request granted
mem_r_valid_i  in  1  read data valid (>=1 cycle after gnt)
mem_r_rdata_i  in  DATA_WIDTH  read data
r_valid_o  out  1  beat valid to R buffer
r_data_o  out  DATA_WIDTH  beat data
r_resp_o  out  2  00 OKAY, 10 SLVERR
r_user_o  out  USER_WIDTH  latched ar_user
r_id_o  out  ID_WIDTH  latched ar_id
r_last_o  out  1  final beat of burst
r_ready_i  in  1  R buffer accepts beat

Behaviour:
- Single clock clk_i; asynchronous active-low reset rst_ni. Reset -> state IDLE, all registers 0, so r_valid_o=0, mem_req_o=0, mem_be_o=0, mem_add_o=0, r_*=0, ar_ready_o=1.
- FSM states: IDLE, REQ, WAIT, SEND, ERR.
- IDLE: ar_ready_o=1. On ar_valid_i, latch addr/len/size/burst/id/user and set beat_cnt=0.
  - Error request goes to ERR: burst=11, size > log2(STRB_WIDTH), or WRAP with len not in {1,3,7,15}.
  - Otherwise go to REQ. ar_ready_o=0 in every other state.
- REQ: mem_req_o=1, with mem_add_o=cur_addr and mem_be_o = ((1<<(1<<size))-1) << (cur_addr mod STRB_WIDTH), aligned-down to size for the mask. mem_gnt_i=1 -> WAIT. Outputs remain stable until gnt.
- WAIT: mem_req_o=0. On mem_r_valid_i, capture rdata into r_data_o, set r_valid_o=1, resp=OKAY, r_last_o=(beat_cnt==len), then go to SEND. mem_r_valid_i is ignored in every other state.
- SEND: hold all r_* stable while r_ready_i=0. On r_ready_i:
  - last -> IDLE.
  - not last -> beat_cnt+1, cur_addr=next_addr, go to REQ.
  - r_valid_o clears in the handshake cycle.
- ERR: no memory access. Present len+1 beats with r_data_o=0, resp=SLVERR, and last on beat len, one beat per cycle while r_ready_i=1. Returns to IDLE after the last beat.
- Address rules, with bytes = 1<<size:
  - FIXED: next = addr.
  - INCR: next = (addr aligned down to bytes) + bytes. Wraps modulo 2^ADDR_WIDTH; no 4KB check.
  - WRAP: mask = (len+1)*bytes-1; next = (addr & ~mask) | ((aligned+bytes) & mask).
- Throughput: 3 cycles/beat minimum when gnt, r_valid and ready all arrive immediately. Exactly one memory read is outstanding at any time.
- r_id_o and r_user_o are constant for the whole burst.
- Reset asserted mid-burst: immediate return to reset values. Any in-flight r_valid after reset is ignored.

Decomposition:
- Shared package axi2mem_pkg:
  - burst encodings BURST_FIXED/INCR/WRAP.
  - resp encodings RESP_OKAY/SLVERR.
  - r_state_t enum (IDLE, REQ, WAIT, SEND, ERR).
- Sub-module axi2mem_burst_addr: combinational next-address and byte-enable computation from addr/len/size/burst. It is reused by the write-path.

Test Plan:
- INCR addr=0x100, len=3, size=3, immediate gnt/r_valid, r_ready=1 -> mem_add 0x100, 0x108, 0x110, 0x118; be=0xFF; 4 OKAY beats, last on the 4th; next AR accepted one cycle later.
- WRAP addr=0x118, len=3, size=3 -> addresses 0x118, 0x100, 0x108, 0x110; last on the 4th; id/user constant across beats.
- INCR addr=0x3, len=1, size=1, 64-bit -> first be=0x0C (addr 0x3 aligned down to 0x2), second addr 0x4 with be=0x30.
- FIXED len=2, with gnt delayed 3 cycles and r_ready low for 5 cycles on beat 1 -> mem_req and mem_add held stable until gnt; r_* held stable until ready; 3 reads all at the same address.
- burst=11, len=2 -> no mem_req ever; 3 SLVERR beats with data 0, last on the 3rd.
- rst_ni low while in SEND -> asynchronously r_valid_o=0 and ar_ready_o=1; a stale mem_r_valid_i after reset produces no beat.

Source files
------------

// File: rtl/axi2mem_pkg.sv
// rtl/axi2mem_pkg.sv - shared encodings and read-path state type for axi2mem
// Purpose: AXI burst/response encodings and the read beat generator FSM states.
// Ports: none (package).
package axi2mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SEND,
        ERR
    } r_state_t;

endpackage

// File: rtl/axi2mem_burst_addr.sv
// rtl/axi2mem_burst_addr.sv - next beat address and byte enables for an AXI burst
// Purpose: combinational address walker shared by the read and write paths.
// Ports: addr_i/len_i/size_i/burst_i describe the current beat;
//        next_addr_o is the following beat address, be_o the lanes of the current beat.
module axi2mem_burst_addr
    import axi2mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            len_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o,
    output logic [STRB_WIDTH-1:0] be_o
);

    logic [ADDR_WIDTH-1:0] bytes_a;
    logic [ADDR_WIDTH-1:0] aligned_a;
    logic [ADDR_WIDTH-1:0] incr_a;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    assign bytes_a   = ADDR_WIDTH'(1) << size_i;
    assign aligned_a = addr_i & ~(bytes_a - ADDR_WIDTH'(1));
    assign incr_a    = aligned_a + bytes_a;
    // Wrap window is (len+1)*bytes; len is restricted to 1/3/7/15 upstream.
    assign wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);

    always_comb begin
        next_addr_o = incr_a;
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_a & wrap_mask);
            default:     next_addr_o = incr_a;
        endcase
    end

    // Lane mask built per lane so oversize requests cannot overflow a shift.
    always_comb begin
        int off;
        int nbytes;
        off    = int'(aligned_a & ADDR_WIDTH'(STRB_WIDTH - 1));
        nbytes = 32'd1 << size_i;
        be_o   = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            be_o[i] = (i >= off) && (i < off + nbytes);
        end
    end

endmodule

// File: rtl/axi2mem_r_beat_gen.sv
// rtl/axi2mem_r_beat_gen.sv - AXI AR burst to memory reads to R-channel beats
// Purpose: accepts one AR burst, issues one req/gnt read per beat, and presents
//          each beat to the R buffer until accepted; illegal bursts return SLVERR.
// Ports: ar_* AR request in; mem_* single-outstanding memory read port;
//        r_* R-channel beat out with r_ready_i backpressure.
module axi2mem_r_beat_gen
    import axi2mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 6,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ar_valid_i,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]            ar_len_i,
    input  logic [2:0]            ar_size_i,
    input  logic [1:0]            ar_burst_i,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [USER_WIDTH-1:0] ar_user_i,
    output logic                  ar_ready_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_add_o,
    output logic                  mem_we_o,
    output logic [STRB_WIDTH-1:0] mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_r_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_r_rdata_i,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic [USER_WIDTH-1:0] r_user_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic                  r_last_o,
    input  logic                  r_ready_i
);

    localparam int LOG2_STRB = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;

    r_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic                  r_valid_q, r_valid_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic                  r_last_q, r_last_d;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [STRB_WIDTH-1:0] beat_be;
    logic                  ar_err;

    axi2mem_burst_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_burst_addr (
        .addr_i      (addr_q),
        .len_i       (len_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr),
        .be_o        (beat_be)
    );

    assign ar_err = (ar_burst_i == BURST_RSVD)
                 || (ar_size_i > 3'(LOG2_STRB))
                 || ((ar_burst_i == BURST_WRAP)
                     && !((ar_len_i == 8'd1) || (ar_len_i == 8'd3)
                          || (ar_len_i == 8'd7) || (ar_len_i == 8'd15)));

    assign ar_ready_o = (state_q == IDLE);
    assign mem_req_o  = (state_q == REQ);
    assign mem_add_o  = mem_req_o ? addr_q : '0;
    assign mem_be_o   = mem_req_o ? beat_be : '0;
    assign mem_we_o   = 1'b0;
    assign r_valid_o  = r_valid_q;
    assign r_data_o   = r_data_q;
    assign r_resp_o   = r_resp_q;
    assign r_user_o   = user_q;
    assign r_id_o     = id_q;
    assign r_last_o   = r_last_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        burst_d   = burst_q;
        id_d      = id_q;
        user_d    = user_q;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        r_last_d  = r_last_q;
        case (state_q)
            IDLE: begin
                if (ar_valid_i) begin
                    addr_d  = ar_addr_i;
                    len_d   = ar_len_i;
                    size_d  = ar_size_i;
                    burst_d = ar_burst_i;
                    id_d    = ar_id_i;
                    user_d  = ar_user_i;
                    cnt_d   = '0;
                    if (ar_err) begin
                        // First error beat is ready immediately; no memory access.
                        state_d   = ERR;
                        r_valid_d = 1'b1;
                        r_data_d  = '0;
                        r_resp_d  = RESP_SLVERR;
                        r_last_d  = (ar_len_i == 8'd0);
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem_r_valid_i) begin
                    r_data_d  = mem_r_rdata_i;
                    r_valid_d = 1'b1;
                    r_resp_d  = RESP_OKAY;
                    r_last_d  = (cnt_q == len_q);
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (r_ready_i) begin
                    r_valid_d = 1'b0;
                    if (r_last_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = REQ;
                    end
                end
            end
            ERR: begin
                if (r_ready_i) begin
                    if (r_last_q) begin
                        r_valid_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d    = cnt_q + 8'd1;
                        r_last_d = ((cnt_q + 8'd1) == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            id_q      <= '0;
            user_q    <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= '0;
            r_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            id_q      <= id_d;
            user_q    <= user_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            r_last_q  <= r_last_d;
        end
    end

endmodule

// File: tb/tb_axi2mem_r_beat_gen.sv
// tb/tb_axi2mem_r_beat_gen.sv - scoreboard bench for axi2mem_r_beat_gen
module tb_axi2mem_r_beat_gen;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ar_valid_i;
    logic [31:0] ar_addr_i;
    logic [7:0]  ar_len_i;
    logic [2:0]  ar_size_i;
    logic [1:0]  ar_burst_i;
    logic [3:0]  ar_id_i;
    logic [5:0]  ar_user_i;
    logic        ar_ready_o;
    logic        mem_req_o;
    logic [31:0] mem_add_o;
    logic        mem_we_o;
    logic [7:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_r_valid_i;
    logic [63:0] mem_r_rdata_i;
    logic        r_valid_o;
    logic [63:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic [5:0]  r_user_o;
    logic [3:0]  r_id_o;
    logic        r_last_o;
    logic        r_ready_i;

    always #5 clk_i = ~clk_i;

    axi2mem_r_beat_gen dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .ar_valid_i    (ar_valid_i),
        .ar_addr_i     (ar_addr_i),
        .ar_len_i      (ar_len_i),
        .ar_size_i     (ar_size_i),
        .ar_burst_i    (ar_burst_i),
        .ar_id_i       (ar_id_i),
        .ar_user_i     (ar_user_i),
        .ar_ready_o    (ar_ready_o),
        .mem_req_o     (mem_req_o),
        .mem_add_o     (mem_add_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_r_valid_i (mem_r_valid_i),
        .mem_r_rdata_i (mem_r_rdata_i),
        .r_valid_o     (r_valid_o),
        .r_data_o      (r_data_o),
        .r_resp_o      (r_resp_o),
        .r_user_o      (r_user_o),
        .r_id_o        (r_id_o),
        .r_last_o      (r_last_o),
        .r_ready_i     (r_ready_i)
    );

    typedef struct { logic [31:0] addr; logic [7:0] be; } mem_exp_t;
    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

    mem_exp_t exp_mem_q[$];
    r_exp_t   exp_r_q[$];
    logic [3:0] exp_id;
    logic [5:0] exp_user;
    int tests_run = 0;
    int fails     = 0;

    function automatic logic [63:0] mem_data(input logic [31:0] a);
        return {a ^ 32'hDEADBEEF, a};
    endfunction

    task automatic push_beat(input logic [31:0] a, input logic [7:0] be, input logic last);
        mem_exp_t m;
        r_exp_t   r;
        m.addr = a; m.be = be;
        r.data = mem_data(a); r.resp = 2'b00; r.last = last;
        exp_mem_q.push_back(m);
        exp_r_q.push_back(r);
    endtask

    task automatic push_err(input logic last);
        r_exp_t r;
        r.data = 64'h0; r.resp = 2'b10; r.last = last;
        exp_r_q.push_back(r);
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [5:0] user);
        tests_run++;
        if (ar_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL ar_ready_before_ar: got %b want 1", ar_ready_o);
        end
        exp_id = id; exp_user = user;
        ar_valid_i = 1'b1; ar_addr_i = a; ar_len_i = len; ar_size_i = size;
        ar_burst_i = burst; ar_id_i = id; ar_user_i = user;
        @(negedge clk_i);
        ar_valid_i = 1'b0;
    endtask

    // Acts as memory (gnt after gnt_dly waiting cycles, r_valid one cycle after gnt)
    // and as R sink (ready held low for hold_cyc cycles on beat hold_beat).
    task automatic run_burst(input int gnt_dly, input int hold_beat, input int hold_cyc);
        int waitc = 0;
        int beat  = 0;
        int holdc = 0;
        bit rv_next = 0;
        bit req_seen = 0;
        logic [31:0] rv_addr = '0;
        logic [31:0] first_addr = '0;
        logic [7:0]  first_be = '0;
        logic [66:0] snap = '0;
        mem_exp_t m;
        r_exp_t   r;
        for (int cyc = 0; cyc < 300 && exp_r_q.size() != 0; cyc++) begin
            mem_gnt_i = 1'b0;
            mem_r_valid_i = 1'b0;
            if (rv_next) begin
                mem_r_valid_i = 1'b1;
                mem_r_rdata_i = mem_data(rv_addr);
                rv_next = 0;
            end
            if (mem_req_o) begin
                if (!req_seen) begin
                    req_seen = 1; waitc = 0;
                    first_addr = mem_add_o; first_be = mem_be_o;
                    tests_run++;
                    if (exp_mem_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_mem_req: got addr %h want no request", mem_add_o);
                    end else begin
                        m = exp_mem_q.pop_front();
                        if (mem_add_o !== m.addr || mem_be_o !== m.be) begin
                            fails++;
                            $display("FAIL mem_addr_be: got %h/%h want %h/%h", mem_add_o, mem_be_o, m.addr, m.be);
                        end
                    end
                end else begin
                    tests_run++;
                    if (mem_add_o !== first_addr || mem_be_o !== first_be) begin
                        fails++;
                        $display("FAIL mem_req_stable: got %h/%h want %h/%h", mem_add_o, mem_be_o, first_addr, first_be);
                    end
                end
                if (waitc >= gnt_dly) begin
                    mem_gnt_i = 1'b1; rv_next = 1; rv_addr = mem_add_o; req_seen = 0;
                end
                waitc++;
            end
            if (r_valid_o) begin
                if (beat == hold_beat && holdc < hold_cyc) begin
                    r_ready_i = 1'b0;
                    if (holdc > 0) begin
                        tests_run++;
                        if ({r_data_o, r_resp_o, r_last_o} !== snap) begin
                            fails++;
                            $display("FAIL r_hold_stable: got %h want %h", {r_data_o, r_resp_o, r_last_o}, snap);
                        end
                    end
                    snap = {r_data_o, r_resp_o, r_last_o};
                    holdc++;
                end else begin
                    r_ready_i = 1'b1;
                    r = exp_r_q.pop_front();
                    tests_run++;
                    if (r_data_o !== r.data || r_resp_o !== r.resp || r_last_o !== r.last) begin
                        fails++;
                        $display("FAIL r_beat%0d: got data %h resp %b last %b want %h %b %b",
                                 beat, r_data_o, r_resp_o, r_last_o, r.data, r.resp, r.last);
                    end
                    tests_run++;
                    if (r_id_o !== exp_id || r_user_o !== exp_user) begin
                        fails++;
                        $display("FAIL r_id_user%0d: got %h/%h want %h/%h", beat, r_id_o, r_user_o, exp_id, exp_user);
                    end
                    beat++;
                end
            end else begin
                r_ready_i = 1'b0;
            end
            @(negedge clk_i);
        end
        mem_gnt_i = 1'b0; mem_r_valid_i = 1'b0; r_ready_i = 1'b0;
        tests_run++;
        if (exp_r_q.size() != 0 || exp_mem_q.size() != 0) begin
            fails++;
            $display("FAIL burst_timeout: got %0d beats/%0d reads pending want 0", exp_r_q.size(), exp_mem_q.size());
        end
        exp_r_q.delete(); exp_mem_q.delete();
        tests_run++;
        if (ar_ready_o !== 1'b1 || r_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_burst: got ar_ready %b r_valid %b want 1 0", ar_ready_o, r_valid_o);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (r_valid_o !== 1'b0 || mem_req_o !== 1'b0 || mem_be_o !== 8'h00 || mem_add_o !== 32'h0
            || r_data_o !== 64'h0 || r_last_o !== 1'b0 || r_id_o !== 4'h0 || r_user_o !== 6'h0
            || r_resp_o !== 2'b00 || ar_ready_o !== 1'b1 || mem_we_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got rv %b req %b be %h add %h ar_ready %b want 0 0 00 0 1",
                     r_valid_o, mem_req_o, mem_be_o, mem_add_o, ar_ready_o);
        end
    endtask

    task automatic test_incr();
        push_beat(32'h100, 8'hFF, 1'b0);
        push_beat(32'h108, 8'hFF, 1'b0);
        push_beat(32'h110, 8'hFF, 1'b0);
        push_beat(32'h118, 8'hFF, 1'b1);
        send_ar(32'h100, 8'd3, 3'd3, 2'b01, 4'h5, 6'h2A);
        run_burst(0, -1, 0);
    endtask

    task automatic test_wrap();
        push_beat(32'h118, 8'hFF, 1'b0);
        push_beat(32'h100, 8'hFF, 1'b0);
        push_beat(32'h108, 8'hFF, 1'b0);
        push_beat(32'h110, 8'hFF, 1'b1);
        send_ar(32'h118, 8'd3, 3'd3, 2'b10, 4'h9, 6'h15);
        run_burst(0, -1, 0);
    endtask

    task automatic test_narrow();
        push_beat(32'h3, 8'h0C, 1'b0);
        push_beat(32'h4, 8'h30, 1'b1);
        send_ar(32'h3, 8'd1, 3'd1, 2'b01, 4'h1, 6'h01);
        run_burst(0, -1, 0);
        push_beat(32'h24, 8'hF0, 1'b0);
        push_beat(32'h20, 8'h0F, 1'b1);
        send_ar(32'h24, 8'd1, 3'd2, 2'b10, 4'hC, 6'h33);
        run_burst(0, -1, 0);
    endtask

    task automatic test_fixed_stall();
        push_beat(32'h40, 8'hFF, 1'b0);
        push_beat(32'h40, 8'hFF, 1'b0);
        push_beat(32'h40, 8'hFF, 1'b1);
        send_ar(32'h40, 8'd2, 3'd3, 2'b00, 4'h7, 6'h3F);
        run_burst(3, 1, 5);
    endtask

    task automatic test_errors();
        push_err(1'b0); push_err(1'b0); push_err(1'b1);
        send_ar(32'h80, 8'd2, 3'd3, 2'b11, 4'h2, 6'h0A);
        run_burst(0, -1, 0);
        push_err(1'b1);
        send_ar(32'h80, 8'd0, 3'd4, 2'b01, 4'h3, 6'h0B);
        run_burst(0, -1, 0);
        push_err(1'b0); push_err(1'b0); push_err(1'b1);
        send_ar(32'h80, 8'd2, 3'd3, 2'b10, 4'h4, 6'h0C);
        run_burst(0, 1, 3);
    endtask

    task automatic test_reset_mid();
        bit rv_next = 0;
        bit seen = 0;
        send_ar(32'h200, 8'd1, 3'd3, 2'b01, 4'h6, 6'h11);
        r_ready_i = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            mem_gnt_i = 1'b0; mem_r_valid_i = 1'b0;
            if (r_valid_o) begin
                seen = 1;
            end else begin
                if (rv_next) begin
                    mem_r_valid_i = 1'b1; mem_r_rdata_i = 64'h1234; rv_next = 0;
                end
                if (mem_req_o) begin
                    mem_gnt_i = 1'b1; rv_next = 1;
                end
                @(negedge clk_i);
            end
        end
        tests_run++;
        if (!seen) begin
            fails++;
            $display("FAIL reset_mid_reach_send: got r_valid %b want 1", r_valid_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        tests_run++;
        if (r_valid_o !== 1'b0 || ar_ready_o !== 1'b1 || mem_req_o !== 1'b0 || r_id_o !== 4'h0) begin
            fails++;
            $display("FAIL async_reset: got r_valid %b ar_ready %b req %b want 0 1 0", r_valid_o, ar_ready_o, mem_req_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        mem_r_valid_i = 1'b1; mem_r_rdata_i = 64'hBAD0BAD0;
        @(negedge clk_i);
        mem_r_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (r_valid_o !== 1'b0 || mem_req_o !== 1'b0 || ar_ready_o !== 1'b1) begin
                fails++;
                $display("FAIL stale_r_valid: got r_valid %b req %b ar_ready %b want 0 0 1", r_valid_o, mem_req_o, ar_ready_o);
            end
            @(negedge clk_i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        ar_valid_i = 1'b0; ar_addr_i = '0; ar_len_i = '0; ar_size_i = '0;
        ar_burst_i = '0; ar_id_i = '0; ar_user_i = '0;
        mem_gnt_i = 1'b0; mem_r_valid_i = 1'b0; mem_r_rdata_i = '0; r_ready_i = 1'b0;
        exp_id = '0; exp_user = '0;
        #13;
        test_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        test_incr();
        test_wrap();
        test_narrow();
        test_fixed_stall();
        test_errors();
        test_reset_mid();
        test_incr();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
